// File: rtl/ds_width_upsizer.sv
// ---------------------------------------------------------------------------
// ds_width_upsizer
//
// Packs RATIO consecutive IWIDTH-bit input words into one IWIDTH*RATIO-bit
// output word. The first word received lands in the LSBs. Intended to sit in
// the read-clock domain of the dual-clock DataStream FIFO and widen that
// stream for wide consumers. Sustains one input word per clock while the
// output side keeps up.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous reset, active low
//   i_dat  : input word
//   i_val  : input word valid
//   i_rdy  : input ready (word moves on i_val & i_rdy)
//   o_dat  : packed output word, word k of a group at [k*IWIDTH +: IWIDTH]
//   o_val  : output word valid
//   o_rdy  : output ready (word moves on o_val & o_rdy)
// ---------------------------------------------------------------------------
module ds_width_upsizer #(
    parameter int IWIDTH = 8,
    parameter int RATIO  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IWIDTH-1:0]        i_dat,
    input  logic                     i_val,
    output logic                     i_rdy,
    output logic [IWIDTH*RATIO-1:0]  o_dat,
    output logic                     o_val,
    input  logic                     o_rdy
);

    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [RATIO-2:0][IWIDTH-1:0]    slot_q;
    logic [IWIDTH*RATIO-1:0]         o_dat_q, o_dat_d;
    logic                            o_val_q, o_val_d;

    logic is_last;
    logic accept;
    logic complete;

    assign is_last  = (cnt_q == LAST_IDX);
    // Only the final word of a group needs the output register free; the
    // earlier words go to the holding slots and may be taken under backpressure.
    assign i_rdy    = ~is_last | ~o_val_q | o_rdy;
    assign accept   = i_val & i_rdy;
    assign complete = accept & is_last;

    assign o_dat = o_dat_q;
    assign o_val = o_val_q;

    // Counter wraps explicitly at RATIO-1 so non-power-of-2 ratios never
    // reach RATIO.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            if (is_last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // A completing group overrides the transfer-clear so back-to-back
    // groups keep o_val high.
    always_comb begin
        o_dat_d = o_dat_q;
        o_val_d = o_val_q;
        if (complete) begin
            o_dat_d = {i_dat, slot_q};
            o_val_d = 1'b1;
        end else if (o_val_q && o_rdy) begin
            o_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            o_dat_q <= '0;
            o_val_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            o_dat_q <= o_dat_d;
            o_val_q <= o_val_d;
        end
    end

    // One holding slot per non-final word position.
    generate
        for (genvar gi = 0; gi < RATIO - 1; gi++) begin : g_slot
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    slot_q[gi] <= '0;
                end else if (accept && (cnt_q == CW'(gi))) begin
                    slot_q[gi] <= i_dat;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ds_width_upsizer.sv
module tb_ds_width_upsizer;

    localparam int IW = 8;
    localparam int RT = 4;

    logic               clk;
    logic               reset;
    logic [IW-1:0]      i_dat;
    logic               i_val;
    logic               i_rdy;
    logic [IW*RT-1:0]   o_dat;
    logic               o_val;
    logic               o_rdy;

    // Second instance with a non-power-of-2 ratio.
    logic               reset3;
    logic [3:0]         i_dat3;
    logic               i_val3;
    logic               i_rdy3;
    logic [11:0]        o_dat3;
    logic               o_val3;
    logic               o_rdy3;

    int checks   = 0;
    int failures = 0;

    // Reference model: accepted words of the current partial group, and
    // completed output words still owed to the consumer.
    logic [IW-1:0]      part_q[$];
    logic [IW*RT-1:0]   out_q[$];
    logic [IW*RT-1:0]   got_q[$];
    int                 n_in = 0;

    ds_width_upsizer #(.IWIDTH(IW), .RATIO(RT)) dut (
        .clk   (clk),
        .reset (reset),
        .i_dat (i_dat),
        .i_val (i_val),
        .i_rdy (i_rdy),
        .o_dat (o_dat),
        .o_val (o_val),
        .o_rdy (o_rdy)
    );

    ds_width_upsizer #(.IWIDTH(4), .RATIO(3)) dut3 (
        .clk   (clk),
        .reset (reset3),
        .i_dat (i_dat3),
        .i_val (i_val3),
        .i_rdy (i_rdy3),
        .o_dat (o_dat3),
        .o_val (o_val3),
        .o_rdy (o_rdy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle against the model; call right after a rising edge.
    task automatic step(input logic iv, input logic [IW-1:0] id, input logic ordy, output logic acc);
        logic exp_rdy;
        logic oxf;
        logic [IW*RT-1:0] w;
        #1;
        i_val = iv;
        i_dat = id;
        o_rdy = ordy;
        @(negedge clk);
        exp_rdy = (part_q.size() != RT - 1) || (out_q.size() == 0) || ordy;
        check("i_rdy", i_rdy, exp_rdy);
        check("o_val", o_val, out_q.size() != 0);
        if (out_q.size() != 0) check("o_dat", o_dat, out_q[0]);
        acc = iv && exp_rdy;
        oxf = (out_q.size() != 0) && ordy;
        @(posedge clk);
        if (oxf) got_q.push_back(out_q.pop_front());
        if (acc) begin
            part_q.push_back(id);
            n_in++;
            if (part_q.size() == RT) begin
                w = '0;
                for (int k = 0; k < RT; k++) w[k*IW +: IW] = part_q[k];
                out_q.push_back(w);
                part_q.delete();
            end
        end
    endtask

    // Present a word until it is taken (bounded).
    task automatic feed(input logic [IW-1:0] id, input logic ordy);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            step(1'b1, id, ordy, acc);
            n++;
        end
        if (!acc) check("feed_timeout", 64'(n), 64'(0));
    endtask

    task automatic model_clear();
        part_q.delete();
        out_q.delete();
        got_q.delete();
    endtask

    initial begin
        logic acc;
        int   cyc;
        logic [11:0] g3[$];

        reset  = 1'b0;
        i_val  = 1'b1;
        i_dat  = 8'h5A;
        o_rdy  = 1'b1;
        reset3 = 1'b0;
        i_val3 = 1'b0;
        i_dat3 = '0;
        o_rdy3 = 1'b1;

        // Reset held with valid input: nothing accepted, outputs cleared.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_o_val", o_val, 1'b0);
            check("rst_o_dat", o_dat, 32'h0);
            check("rst_i_rdy", i_rdy, 1'b1);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        i_val = 1'b0;
        feed(8'h11, 1'b0);
        feed(8'h22, 1'b0);
        feed(8'h33, 1'b0);
        feed(8'h44, 1'b0);
        step(1'b0, 8'h00, 1'b1, acc);
        check("rst_grp_cnt", 64'(got_q.size()), 64'(1));
        if (got_q.size() > 0) check("rst_grp", got_q[0], 32'h44332211);
        model_clear();

        // Full-rate streaming.
        for (int k = 0; k < 16; k++) feed(8'(k), 1'b1);
        step(1'b0, 8'h00, 1'b1, acc);
        check("stream_cnt", 64'(got_q.size()), 64'(4));
        if (got_q.size() == 4) begin
            check("stream0", got_q[0], 32'h03020100);
            check("stream1", got_q[1], 32'h07060504);
            check("stream2", got_q[2], 32'h0B0A0908);
            check("stream3", got_q[3], 32'h0F0E0D0C);
        end
        model_clear();

        // Backpressure: second group fills slots, stalls on its last word.
        for (int k = 0; k < 7; k++) feed(8'(8'h20 + k), 1'b0);
        for (int c = 0; c < 3; c++) step(1'b1, 8'h27, 1'b0, acc);
        check("bp_stall_acc", acc, 1'b0);
        feed(8'h27, 1'b1);
        step(1'b0, 8'h00, 1'b1, acc);
        check("bp_cnt", 64'(got_q.size()), 64'(2));
        if (got_q.size() == 2) begin
            check("bp0", got_q[0], 32'h23222120);
            check("bp1", got_q[1], 32'h27262524);
        end
        model_clear();

        // Mid-group asynchronous reset between clock edges.
        feed(8'hAA, 1'b1);
        feed(8'hBB, 1'b1);
        #1 i_val = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("mid_rst_o_val", o_val, 1'b0);
        check("mid_rst_o_dat", o_dat, 32'h0);
        #1 reset = 1'b1;
        @(posedge clk);
        model_clear();
        for (int k = 1; k <= 4; k++) feed(8'(k), 1'b1);
        step(1'b0, 8'h00, 1'b1, acc);
        check("mid_rst_cnt", 64'(got_q.size()), 64'(1));
        if (got_q.size() > 0) check("mid_rst_grp", got_q[0], 32'h04030201);
        model_clear();

        // Random handshakes against the model.
        n_in = 0;
        cyc  = 0;
        begin
            int n_out;
            n_out = 0;
            while (n_in < 10000 && cyc < 60000) begin
                step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), acc);
                n_out += got_q.size();
                got_q.delete();
                cyc++;
            end
            check("rand_done", 64'(n_in >= 10000), 64'(1));
            for (int c = 0; c < 4; c++) begin
                step(1'b0, 8'h00, 1'b1, acc);
                n_out += got_q.size();
                got_q.delete();
            end
            check("rand_out_cnt", 64'(n_out), 64'(n_in / RT));
        end

        // RATIO=3, IWIDTH=4 instance.
        @(posedge clk);
        #1 reset3 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            i_val3 = (k <= 6);
            i_dat3 = 4'(k);
            @(negedge clk);
            check("r3_i_rdy", i_rdy3, 1'b1);
            if (o_val3) g3.push_back(o_dat3);
            @(posedge clk);
            #1;
        end
        check("r3_cnt", 64'(g3.size()), 64'(2));
        if (g3.size() == 2) begin
            check("r3_w0", g3[0], 12'h321);
            check("r3_w1", g3[1], 12'h654);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
